// File: rtl/piso_shift_param.sv
// Parametrised parallel-in/serial-out shift register with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every frame.
module piso_shift_param #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] word);
    logic [WIDTH-1:0] rev;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = word[WIDTH-1-i];
    end
    return rev;
  endfunction

  // LSB-first words are pre-reversed so the shifter only ever drains from the MSB end.
  function automatic logic [FRAME-1:0] frame_word(input logic [WIDTH-1:0] data,
                                                  input logic             msb);
    logic [WIDTH-1:0] ordered;
    ordered = msb ? data : bit_reverse(data);
`ifdef PISO_PARITY_EN
    return {ordered, ^data};
`else
    return ordered;
`endif
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [FRAME-1:0] sreg;
  logic [FRAME-1:0] sreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_nxt;
  logic             valid_nxt;
  logic             accept;
  logic             transfer;

  assign ser_last   = (cnt == '0) & ser_valid;
  assign load_ready = rst_n & ((state == IDLE) | (ser_valid & ser_last & ser_ready));
  assign accept     = load_valid & load_ready;
  assign transfer   = ser_valid & ser_ready;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    // A load takes priority so the next frame follows the last bit with no gap.
    if (accept) begin
      sreg_nxt  = frame_word(load_data, msb_first);
      cnt_nxt   = CNT_W'(FRAME - 1);
      state_nxt = SHIFT;
    end else if (transfer) begin
      sreg_nxt = sreg << 1;
      if (cnt == '0) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
    valid_nxt = (state_nxt == SHIFT);
    out_nxt   = valid_nxt ? sreg_nxt[FRAME-1] : IDLE_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      ser_out   <= out_nxt;
      ser_valid <= valid_nxt;
      busy      <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_piso_shift_param.sv
// Directed bench for piso_shift_param (WIDTH=8, IDLE_LEVEL=1); follows PISO_PARITY_EN.
module tb_piso_shift_param;

`ifdef PISO_PARITY_EN
  localparam int FR  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FR  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       msb_first;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic       ser_ready;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  piso_shift_param #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .msb_first  (msb_first),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .ser_ready  (ser_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Hand-written bit sequence (first bit at the MSB) plus its parity bit when enabled.
  function automatic logic [15:0] fr(input logic [7:0] bits, input logic p);
    return PAR ? {7'b0, bits, p} : {8'b0, bits};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_out"},   ser_out,    1'b1);
    chk({tag, "_valid"}, ser_valid,  1'b0);
    chk({tag, "_busy"},  busy,       1'b0);
    chk({tag, "_last"},  ser_last,   1'b0);
    chk({tag, "_ready"}, load_ready, 1'b1);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic load(input logic [7:0] data, input logic msb);
    load_valid = 1'b1;
    load_data  = data;
    msb_first  = msb;
    chk("load_ready", load_ready, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 8'h5A;
    msb_first  = ~msb;
  endtask

  task automatic recv(input string tag, input logic [15:0] exp, input int ncons,
                      input int stall_k, input int stall_len, input bit chain);
    for (int k = 0; k < ncons; k++) begin
      if (k == stall_k) begin
        for (int s = 0; s < stall_len; s++) begin
          ser_ready = 1'b0;
          chk($sformatf("%s_stall%0d_out", tag, s),   ser_out,    exp[FR-1-k]);
          chk($sformatf("%s_stall%0d_valid", tag, s), ser_valid,  1'b1);
          chk($sformatf("%s_stall%0d_last", tag, s),  ser_last,   1'b0);
          chk($sformatf("%s_stall%0d_ready", tag, s), load_ready, 1'b0);
          @(negedge clk);
        end
      end
      ser_ready = 1'b1;
      chk($sformatf("%s_b%0d_out", tag, k),   ser_out,    exp[FR-1-k]);
      chk($sformatf("%s_b%0d_valid", tag, k), ser_valid,  1'b1);
      chk($sformatf("%s_b%0d_busy", tag, k),  busy,       1'b1);
      chk($sformatf("%s_b%0d_last", tag, k),  ser_last,   k == FR - 1);
      chk($sformatf("%s_b%0d_ready", tag, k), load_ready, k == FR - 1);
      @(negedge clk);
    end
    if (ncons == FR && !chain) check_idle({tag, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    msb_first  = 1'b1;
    ser_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready_low", load_ready, 1'b0);
    chk("rst_valid",     ser_valid,  1'b0);
    chk("rst_out",       ser_out,    1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // 0x1E MSB first: 0,0,0,1,1,1,1,0 (+ parity 0)
    load(8'h1E, 1'b1);
    recv("msb1e", fr(8'b00011110, 1'b0), FR, -1, 0, 1'b0);

    // 0x1E LSB first: 0,1,1,1,1,0,0,0 (+ parity 0), 3-cycle stall before bit index 2
    load(8'h1E, 1'b0);
    recv("lsb1e", fr(8'b01111000, 1'b0), FR, 2, 3, 1'b0);

    // Back-to-back 0xFF then 0x00 with load_valid held throughout the first frame
    load(8'hFF, 1'b1);
    load_valid = 1'b1;
    load_data  = 8'h00;
    msb_first  = 1'b1;
    recv("b2b_ff", fr(8'b11111111, 1'b0), FR, -1, 0, 1'b1);
    load_valid = 1'b0;
    recv("b2b_00", fr(8'b00000000, 1'b0), FR, -1, 0, 1'b0);

    // Reset after three bits of 0xA5 (1,0,1,...)
    load(8'hA5, 1'b1);
    recv("a5", fr(8'b10100101, 1'b0), 3, -1, 0, 1'b0);
    rst_n = 1'b0;
    chk("mid_rst_ready", load_ready, 1'b0);
    @(negedge clk);
    chk("mid_rst_valid", ser_valid, 1'b0);
    chk("mid_rst_out",   ser_out,   1'b1);
    chk("mid_rst_busy",  busy,      1'b0);
    chk("mid_rst_last",  ser_last,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    load(8'h0F, 1'b1);
    recv("x0f", fr(8'b00001111, 1'b0), FR, -1, 0, 1'b0);

    // 0x07 MSB first: five 0s, three 1s (+ parity 1 on the last bit)
    load(8'h07, 1'b1);
    recv("x07", fr(8'b00000111, 1'b1), FR, 4, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
